// File: rtl/pmod_enc_pkg.sv
// Shared definitions for the Pmod ENC decoder: quadrature phase encoding,
// direction constants and the clockwise phase successor.
package pmod_enc_pkg;

    typedef enum logic [1:0] {
        P00 = 2'b00,
        P01 = 2'b01,
        P10 = 2'b10,
        P11 = 2'b11
    } phase_t;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    // Clockwise order is P00 -> P10 -> P11 -> P01 -> P00.
    function automatic phase_t cw_next(input phase_t p);
        phase_t n;
        unique case (p)
            P00:     n = P10;
            P10:     n = P11;
            P11:     n = P01;
            default: n = P00;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchronizer followed by a stability filter: the output follows the
// synchronized input only after it has disagreed for WINDOW consecutive cycles.
module enc_debounce #(
    parameter int   WINDOW  = 1000,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam int CNT_BITS = $clog2(WINDOW + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(WINDOW - 1);

    logic                sync1_reg;
    logic                sync2_reg;
    logic                filt_reg;
    logic [CNT_BITS-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= RST_VAL;
            sync2_reg <= RST_VAL;
            filt_reg  <= RST_VAL;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            // Any agreement with the filtered value restarts the window.
            if (sync2_reg == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                filt_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_BITS'(1);
            end
        end
    end

    assign filt = filt_reg;

endmodule

// File: rtl/pmod_enc_decoder.sv
// Pmod ENC decoder: filtered quadrature tracking with detent-level steps, a
// wrapping position counter, button clear and debounced switch level.
module pmod_enc_decoder
    import pmod_enc_pkg::*;
#(
    parameter int FILT_CYCLES = 1000,
    parameter int DEB_CYCLES  = 100000,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             enc_btn,
    input  logic             enc_swt,
    output logic [CNT_W-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             btn_pulse,
    output logic             swt_level,
    output logic             seq_err
);

    // Cycles after reset release until the filters reflect the real inputs.
    localparam int SETTLE = FILT_CYCLES + 3;
    localparam int SET_W  = $clog2(SETTLE + 1);

    logic [1:0] enc_raw;
    logic [1:0] enc_filt;
    logic [1:0] ui_raw;
    logic [1:0] ui_filt;

    assign enc_raw = {enc_a, enc_b};
    assign ui_raw  = {enc_btn, enc_swt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_enc
            enc_debounce #(.WINDOW(FILT_CYCLES), .RST_VAL(1'b1)) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (enc_raw[gi]),
                .filt (enc_filt[gi])
            );
        end
        for (gi = 0; gi < 2; gi++) begin : g_ui
            enc_debounce #(.WINDOW(DEB_CYCLES), .RST_VAL(1'b0)) u_deb (
                .clk  (clk),
                .rst_n(rst_n),
                .raw  (ui_raw[gi]),
                .filt (ui_filt[gi])
            );
        end
    endgenerate

    phase_t            phase_reg;
    phase_t            ab_now;
    logic signed [2:0] sub_reg;
    logic [SET_W-1:0]  settle_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              step_reg;
    logic              dir_reg;
    logic              seq_err_reg;
    logic              btn_prev_reg;
    logic              btn_pulse_reg;

    logic settling;
    logic mv_cw;
    logic mv_ccw;
    logic mv_err;
    logic step_cw;
    logic step_ccw;

    assign ab_now   = phase_t'(enc_filt);
    assign settling = (settle_reg != SET_W'(SETTLE));
    assign mv_cw    = (ab_now == cw_next(phase_reg));
    assign mv_ccw   = (phase_reg == cw_next(ab_now));
    assign mv_err   = (ab_now != phase_reg) && !mv_cw && !mv_ccw;
    // A detent completes on the fourth same-direction move, which lands on P00.
    assign step_cw  = !settling && mv_cw  && (ab_now == P00) && (sub_reg == 3'sd3);
    assign step_ccw = !settling && mv_ccw && (ab_now == P00) && (sub_reg == -3'sd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg     <= P11;
            sub_reg       <= '0;
            settle_reg    <= '0;
            count_reg     <= '0;
            step_reg      <= 1'b0;
            dir_reg       <= DIR_CW;
            seq_err_reg   <= 1'b0;
            btn_prev_reg  <= 1'b0;
            btn_pulse_reg <= 1'b0;
        end else begin
            step_reg      <= step_cw || step_ccw;
            seq_err_reg   <= 1'b0;
            btn_prev_reg  <= ui_filt[1];
            btn_pulse_reg <= ui_filt[1] && !btn_prev_reg;

            if (settling) begin
                settle_reg <= settle_reg + SET_W'(1);
                phase_reg  <= ab_now;
                sub_reg    <= '0;
            end else if (mv_err) begin
                seq_err_reg <= 1'b1;
                phase_reg   <= ab_now;
                sub_reg     <= '0;
            end else if (mv_cw || mv_ccw) begin
                phase_reg <= ab_now;
                if (ab_now == P00) begin
                    sub_reg <= '0;
                end else if (mv_cw) begin
                    sub_reg <= sub_reg + 3'sd1;
                end else begin
                    sub_reg <= sub_reg - 3'sd1;
                end
            end

            if (step_cw) begin
                dir_reg <= DIR_CW;
            end else if (step_ccw) begin
                dir_reg <= DIR_CCW;
            end

            // A pending button clear overrides a step landing in the same cycle.
            if (btn_pulse_reg) begin
                count_reg <= '0;
            end else if (step_cw) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (step_ccw) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    assign count     = count_reg;
    assign step      = step_reg;
    assign dir       = dir_reg;
    assign seq_err   = seq_err_reg;
    assign btn_pulse = btn_pulse_reg;
    assign swt_level = ui_filt[0];

endmodule

// File: tb/tb_pmod_enc_decoder.sv
// Self-checking bench for pmod_enc_decoder: directed scenarios plus a random
// walk of phases, buttons and switch toggles against a detent-level model.
module tb_pmod_enc_decoder;

    localparam int FILT = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enc_a = 1'b1;
    logic       enc_b = 1'b1;
    logic       enc_btn = 1'b0;
    logic       enc_swt = 1'b0;
    logic [3:0] count;
    logic       step;
    logic       dir;
    logic       btn_pulse;
    logic       swt_level;
    logic       seq_err;

    always #5 clk = ~clk;

    pmod_enc_decoder #(.FILT_CYCLES(FILT), .DEB_CYCLES(DEB), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .enc_btn  (enc_btn),
        .enc_swt  (enc_swt),
        .count    (count),
        .step     (step),
        .dir      (dir),
        .btn_pulse(btn_pulse),
        .swt_level(swt_level),
        .seq_err  (seq_err)
    );

    int total = 0;
    int bad = 0;

    // Pulse counters, sampled mid-cycle.
    int step_seen = 0;
    int err_seen = 0;
    int btnp_seen = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (step) step_seen++;
            if (seq_err) err_seen++;
            if (btn_pulse) btnp_seen++;
        end
    end

    // Model: phase index in CW order, net quarter-turns since last P00 entry.
    int m_idx = 2;
    int m_net = 0;
    int m_count = 0;
    bit m_dir = 1'b1;
    int m_steps = 0;
    int m_errs = 0;
    int m_btn = 0;

    function automatic int idx_of(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] ab_of(input int i);
        case (i % 4)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic model_move(input logic [1:0] ab);
        int n;
        int d;
        n = idx_of(ab);
        d = (n - m_idx + 4) % 4;
        if (d == 2) begin
            m_errs++;
            m_net = 0;
        end else if (d != 0) begin
            m_net += (d == 1) ? 1 : -1;
            if (n == 0) begin
                if (m_net == 4) begin
                    m_count = (m_count + 1) % 16;
                    m_dir = 1'b1;
                    m_steps++;
                end else if (m_net == -4) begin
                    m_count = (m_count + 15) % 16;
                    m_dir = 1'b0;
                    m_steps++;
                end
                m_net = 0;
            end
        end
        m_idx = n;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
        model_move(ab);
    endtask

    task automatic move(input logic [1:0] ab, input int hold);
        drive_ab(ab);
        repeat (hold) tick();
    endtask

    task automatic detent(input bit cw);
        if (cw) begin
            move(2'b10, HOLD); move(2'b11, HOLD); move(2'b01, HOLD); move(2'b00, HOLD);
        end else begin
            move(2'b01, HOLD); move(2'b11, HOLD); move(2'b10, HOLD); move(2'b00, HOLD);
        end
    endtask

    task automatic press_button();
        enc_btn = 1'b1;
        repeat (HOLD) tick();
        enc_btn = 1'b0;
        repeat (HOLD) tick();
        m_count = 0;
        m_btn++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enc_a = 1'b0;
        enc_b = 1'b0;
        repeat (3) tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
        total++; if (step !== 1'b0) begin bad++; $display("FAIL rst_step got=%b want=0", step); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL rst_dir got=%b want=1", dir); end
        total++; if (btn_pulse !== 1'b0) begin bad++; $display("FAIL rst_btn got=%b want=0", btn_pulse); end
        total++; if (swt_level !== 1'b0) begin bad++; $display("FAIL rst_swt got=%b want=0", swt_level); end
        total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", seq_err); end
        // Release with the encoder parked at P00: first phase adopted silently.
        rst_n = 1'b1;
        m_idx = 0;
        repeat (15) tick();
        total++; if (err_seen !== 0) begin bad++; $display("FAIL rel_err got=%0d want=0", err_seen); end
        total++; if (step_seen !== 0) begin bad++; $display("FAIL rel_step got=%0d want=0", step_seen); end
        $display("test_reset done");
    endtask

    task automatic test_cw_latency();
        move(2'b10, HOLD); move(2'b11, HOLD); move(2'b01, HOLD);
        drive_ab(2'b00);
        repeat (6) tick();
        total++; if (step !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", step); end
        tick();
        total++; if (step !== 1'b1) begin bad++; $display("FAIL lat_step got=%b want=1", step); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL lat_dir got=%b want=1", dir); end
        total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL lat_count got=%0d want=%0d", count, m_count); end
        tick();
        total++; if (step !== 1'b0) begin bad++; $display("FAIL lat_pulse got=%b want=0", step); end
        repeat (HOLD) tick();
        $display("test_cw_latency done count=%0d", count);
    endtask

    task automatic test_wrap();
        press_button();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wrap_clr got=%0d want=0", count); end
        total++; if (btnp_seen !== m_btn) begin bad++; $display("FAIL wrap_btnp got=%0d want=%0d", btnp_seen, m_btn); end
        detent(1'b0);
        total++; if (count !== 4'd15) begin bad++; $display("FAIL wrap_ccw got=%0d want=15", count); end
        for (int i = 0; i < 16; i++) begin
            detent(1'b1);
            $display("wrap detent %0d count=%0d exp=%0d", i, count, m_count);
            total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL wrap_cw%0d got=%0d want=%0d", i, count, m_count); end
        end
        total++; if (count !== 4'd15) begin bad++; $display("FAIL wrap_end got=%0d want=15", count); end
        detent(1'b1);
        detent(1'b0);
        total++; if (count !== 4'd15) begin bad++; $display("FAIL wrap_back got=%0d want=15", count); end
        total++; if (dir !== 1'b0) begin bad++; $display("FAIL wrap_dir got=%b want=0", dir); end
    endtask

    task automatic test_seq_err();
        int c0;
        int s0;
        c0 = int'(count);
        s0 = step_seen;
        move(2'b11, HOLD);
        total++; if (err_seen !== m_errs) begin bad++; $display("FAIL err_pulse got=%0d want=%0d", err_seen, m_errs); end
        total++; if (count !== 4'(c0)) begin bad++; $display("FAIL err_count got=%0d want=%0d", count, c0); end
        total++; if (step_seen !== s0) begin bad++; $display("FAIL err_step got=%0d want=%0d", step_seen, s0); end
        move(2'b00, HOLD);
        detent(1'b1);
        total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL err_after got=%0d want=%0d", count, m_count); end
        total++; if (dir !== m_dir) begin bad++; $display("FAIL err_dir got=%b want=%b", dir, m_dir); end
        $display("test_seq_err done errs=%0d", err_seen);
    endtask

    task automatic test_half_detent();
        int c0;
        int s0;
        c0 = int'(count);
        s0 = step_seen;
        move(2'b10, HOLD); move(2'b11, HOLD); move(2'b10, HOLD); move(2'b00, HOLD);
        total++; if (step_seen !== s0) begin bad++; $display("FAIL half_step got=%0d want=%0d", step_seen, s0); end
        total++; if (count !== 4'(c0)) begin bad++; $display("FAIL half_count got=%0d want=%0d", count, c0); end
        $display("test_half_detent done");
    endtask

    task automatic test_glitch();
        int e0;
        e0 = err_seen;
        enc_a = 1'b1;
        repeat (3) tick();
        enc_a = 1'b0;
        repeat (HOLD) tick();
        total++; if (err_seen !== e0) begin bad++; $display("FAIL glitch_err got=%0d want=%0d", err_seen, e0); end
        detent(1'b1);
        total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL glitch_count got=%0d want=%0d", count, m_count); end
        total++; if (step_seen !== m_steps) begin bad++; $display("FAIL glitch_steps got=%0d want=%0d", step_seen, m_steps); end
        $display("test_glitch done");
    endtask

    task automatic test_btn_step();
        move(2'b10, HOLD); move(2'b11, HOLD); move(2'b01, HOLD);
        enc_btn = 1'b1;
        tick();
        drive_ab(2'b00);
        m_count = 0;
        m_btn++;
        repeat (6) tick();
        total++; if (btn_pulse !== 1'b1) begin bad++; $display("FAIL bs_btn got=%b want=1", btn_pulse); end
        tick();
        total++; if (step !== 1'b1) begin bad++; $display("FAIL bs_step got=%b want=1", step); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL bs_dir got=%b want=1", dir); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL bs_count got=%0d want=0", count); end
        enc_btn = 1'b0;
        repeat (HOLD) tick();
        $display("test_btn_step done");
    endtask

    task automatic test_reset_mid();
        detent(1'b1);
        move(2'b10, HOLD); move(2'b11, HOLD);
        rst_n = 1'b0;
        tick();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rm_count got=%0d want=0", count); end
        total++; if (dir !== 1'b1) begin bad++; $display("FAIL rm_dir got=%b want=1", dir); end
        total++; if ((step | seq_err | btn_pulse) !== 1'b0) begin bad++; $display("FAIL rm_pulses got=%b%b%b want=000", step, seq_err, btn_pulse); end
        rst_n = 1'b1;
        m_idx = 2; m_net = 0; m_count = 0; m_dir = 1'b1;
        repeat (12) tick();
        move(2'b01, HOLD); move(2'b00, HOLD);
        total++; if (step_seen !== m_steps) begin bad++; $display("FAIL rm_nostep got=%0d want=%0d", step_seen, m_steps); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL rm_count2 got=%0d want=0", count); end
        detent(1'b1);
        total++; if (count !== 4'd1) begin bad++; $display("FAIL rm_detent got=%0d want=1", count); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int r;
        int hold;
        string op;
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            hold = $urandom_range(HOLD, HOLD + 5);
            if (r < 7) begin
                op = ($urandom_range(0, 1) == 1) ? "cw" : "ccw";
                move(ab_of(m_idx + ((op == "cw") ? 1 : 3)), hold);
            end else if (r == 7) begin
                op = "illegal";
                move(ab_of(m_idx + 2), hold);
            end else if (r == 8) begin
                op = "switch";
                enc_swt = ~enc_swt;
                repeat (hold) tick();
            end else begin
                op = "button";
                press_button();
            end
            $display("txn %0d op=%s count=%0d exp=%0d dir=%b steps=%0d/%0d errs=%0d/%0d",
                     t, op, count, m_count, dir, step_seen, m_steps, err_seen, m_errs);
            total++; if (count !== 4'(m_count)) begin bad++; $display("FAIL rnd_count%0d got=%0d want=%0d", t, count, m_count); end
            total++; if (dir !== m_dir) begin bad++; $display("FAIL rnd_dir%0d got=%b want=%b", t, dir, m_dir); end
            total++; if (step_seen !== m_steps) begin bad++; $display("FAIL rnd_steps%0d got=%0d want=%0d", t, step_seen, m_steps); end
            total++; if (err_seen !== m_errs) begin bad++; $display("FAIL rnd_errs%0d got=%0d want=%0d", t, err_seen, m_errs); end
            total++; if (swt_level !== enc_swt) begin bad++; $display("FAIL rnd_swt%0d got=%b want=%b", t, swt_level, enc_swt); end
            total++; if (btnp_seen !== m_btn) begin bad++; $display("FAIL rnd_btn%0d got=%0d want=%0d", t, btnp_seen, m_btn); end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_cw_latency();
        test_wrap();
        test_seq_err();
        test_half_detent();
        test_glitch();
        test_btn_step();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
